sp_ram_arbiter: RTL

//  Shares one sp_ram port between NUM_REQ requesters with round-robin arbitration.

---
 rtl/sp_ram_arb_pkg.sv | 36 +++
 rtl/sp_ram_arbiter_if.sv | 30 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/sp_ram_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Purpose : shared helpers for the single-port RAM arbiter (pointer width, one-hot decode, saturation value).
// Latency : n/a (package, no logic).
// Backpressure: n/a.
package sp_ram_arb_pkg;

    // Upper bound on requesters; the one-hot decoder is sized for it.
    localparam int MAX_REQ = 8;

    // All-ones reference; counters compare against its low CNT_WIDTH bits to saturate.
    localparam logic [31:0] SAT_ONES = 32'hFFFF_FFFF;

    // Ceiling log2, never less than 1 so a 2-requester pointer still has one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index of the set bit in a one-hot vector (zero when the vector is empty).
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Purpose : requester-side bundle of the RAM arbiter (requests, grants, read return).
// Latency : grant same cycle as request; read data one cycle after grant.
// Backpressure: a requester holds req and its fields stable until it sees its gnt bit.
//   req/req_wr/req_addr/req_w_data : from requesters (flattened, requester i at [i*W +: W])
//   gnt/rd_valid/rd_data           : to requesters
interface sp_ram_arbiter_if
    import sp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_w_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]         rd_data;

    modport master (
        output req, req_wr, req_addr, req_w_data,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, req_wr, req_addr, req_w_data,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin picker; first asserted req at or after ptr wins.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; losers simply see no grant and keep requesting.
//   req_i/ptr_i in; gnt_o one-hot, idx_o winner index, any_o = some grant issued.
module rr_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] gnt;
    logic               found;
    int                 pos;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        for (int o = 0; o < NUM_REQ; o++) begin
            // ptr is always < NUM_REQ, so one conditional subtract wraps the scan.
            pos = int'(ptr_i) + o;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req_i[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign gnt_o = gnt;
    assign any_o = found;
    assign idx_o = PTR_W'(onehot_to_idx(MAX_REQ'(gnt)));

endmodule

// File: rtl/sp_ram_arbiter.sv
// Purpose : shares one single-port RAM between NUM_REQ requesters, round-robin, one access per cycle.
// Latency : grant and RAM drive in the request cycle; rd_valid/rd_data one cycle after a read grant.
// Backpressure: ungranted requesters hold their request; no queuing inside the arbiter.
//   clk, rst (sync, active-high); req_bus = requester interface (slave side);
//   ram_wr_rdn/ram_addr/ram_w_data to RAM, ram_r_data from RAM; stat_* statistics counters.
//   Define SP_RAM_ARB_STATS_EN to build the saturating stat_* counters; otherwise they read 0.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sp_ram_arbiter_if.slave       req_bus,
    output logic                  ram_wr_rdn,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    input  logic [DATA_WIDTH-1:0] ram_r_data,
    output logic [CNT_WIDTH-1:0]  stat_wr_cnt,
    output logic [CNT_WIDTH-1:0]  stat_rd_cnt,
    output logic [CNT_WIDTH-1:0]  stat_cfl_cnt
);

    localparam int PTR_W = clog2(NUM_REQ);

    logic [PTR_W-1:0]      ptr_q, ptr_d, arb_idx;
    logic [NUM_REQ-1:0]    arb_gnt, gnt, rd_valid_q, rd_valid_d;
    logic                  arb_any, grant_vld, grant_wr;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, grant_addr;
    logic [DATA_WIDTH-1:0] grant_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i (req_bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        grant_vld   = arb_any & ~rst;
        gnt         = grant_vld ? arb_gnt : '0;
        grant_wr    = req_bus.req_wr[arb_idx];
        grant_addr  = req_bus.req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        grant_wdata = req_bus.req_w_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];

        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
        end
        addr_d     = grant_vld ? grant_addr : addr_q;
        rd_valid_d = grant_wr ? '0 : gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            addr_q     <= '0;
            rd_valid_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Idle cycles park the address on the last granted one and never write.
    assign ram_wr_rdn = grant_vld & grant_wr;
    assign ram_addr   = grant_vld ? grant_addr : addr_q;
    assign ram_w_data = grant_vld ? grant_wdata : '0;

    assign req_bus.gnt      = gnt;
    // A read granted just before reset must not surface while rst is high.
    assign req_bus.rd_valid = rd_valid_q & ~{NUM_REQ{rst}};
    assign req_bus.rd_data  = ram_r_data;

`ifdef SP_RAM_ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = SAT_ONES[CNT_WIDTH-1:0];

    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, cfl_cnt_q, cfl_cnt_d;
    logic                 multi_req;

    always_comb begin
        // With several requests only one can win, so every such cycle stalls someone.
        multi_req = ($countones(req_bus.req) > 1) && !rst;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        cfl_cnt_d = cfl_cnt_q;
        if (grant_vld && grant_wr && (wr_cnt_q != CNT_SAT)) begin
            wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
        end
        if (grant_vld && !grant_wr && (rd_cnt_q != CNT_SAT)) begin
            rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        end
        if (multi_req && (cfl_cnt_q != CNT_SAT)) begin
            cfl_cnt_d = cfl_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            cfl_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            cfl_cnt_q <= cfl_cnt_d;
        end
    end

    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_cfl_cnt = cfl_cnt_q;
`else
    assign stat_wr_cnt  = '0;
    assign stat_rd_cnt  = '0;
    assign stat_cfl_cnt = '0;
`endif

endmodule
